and_1: RTL and testbench

//   Registered two-input AND cell with a complementary NAND output.

---
 rtl/logic_cells_pkg.sv | 12 +
 rtl/and_1_pipe_reg.sv | 22 ++
 rtl/and_1.sv | 60 ++++++
 tb/tb_and_1.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/logic_cells_pkg.sv
// rtl/logic_cells_pkg.sv - shared constants and helpers for the logic-gate cells
package logic_cells_pkg;

  localparam int MAX_PIPE_STAGES = 4;

  // A signed one-bit -1 sign-extends to all ones at any width it is cast to,
  // so one helper serves every WIDTH of NAND output.
  function automatic logic signed [0:0] nand_reset_value();
    return 1'sb1;
  endfunction

endpackage

// File: rtl/and_1_pipe_reg.sv
// rtl/and_1_pipe_reg.sv - WIDTH-bit pipeline register with synchronous reset to a chosen value
module and_1_pipe_reg
  import logic_cells_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RST_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_VALUE;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/and_1.sv
// rtl/and_1.sv - registered bitwise AND cell with complementary NAND output
module and_1
  import logic_cells_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int PIPE_STAGES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] x
);

  localparam logic [WIDTH-1:0] X_RST = WIDTH'(nand_reset_value());

  if (WIDTH < 1 || PIPE_STAGES < 0 || PIPE_STAGES > MAX_PIPE_STAGES) begin : g_param_check
    $error("and_1: WIDTH=%0d PIPE_STAGES=%0d out of range", WIDTH, PIPE_STAGES);
  end

  // Index 0 is the combinational gate; index k is the output of register stage k.
  logic [PIPE_STAGES:0][WIDTH-1:0] y_chain;
  logic [PIPE_STAGES:0][WIDTH-1:0] x_chain;

  assign y_chain[0] = a & b;
  assign x_chain[0] = ~(a & b);

  for (genvar i = 0; i < PIPE_STAGES; i++) begin : g_stage
    and_1_pipe_reg #(
      .WIDTH     (WIDTH),
      .RST_VALUE ('0)
    ) u_y_reg (
      .clk (clk),
      .rst (rst),
      .d   (y_chain[i]),
      .q   (y_chain[i+1])
    );

    and_1_pipe_reg #(
      .WIDTH     (WIDTH),
      .RST_VALUE (X_RST)
    ) u_x_reg (
      .clk (clk),
      .rst (rst),
      .d   (x_chain[i]),
      .q   (x_chain[i+1])
    );
  end

  // With no registers the cell is pure logic and clk/rst go nowhere.
  if (PIPE_STAGES == 0) begin : g_comb_only
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
  end

  assign y = y_chain[PIPE_STAGES];
  assign x = x_chain[PIPE_STAGES];

endmodule

// File: tb/tb_and_1.sv
// tb/tb_and_1.sv - self-checking bench for and_1 across three parameter sets
module tb_and_1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] a8  = '0;
  logic [7:0] b8  = '0;

  logic [0:0] y_p1, x_p1, y_p0, x_p0;
  logic [7:0] y_p3, x_p3;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-edge history of the requested AND result and of rst.
  logic [7:0] hist_and[$];
  logic       hist_rst[$];

  always #5 clk = ~clk;

  and_1 #(.WIDTH(1), .PIPE_STAGES(1)) u_w1_p1 (
    .clk(clk), .rst(rst), .a(a8[0:0]), .b(b8[0:0]), .y(y_p1), .x(x_p1)
  );

  and_1 #(.WIDTH(8), .PIPE_STAGES(3)) u_w8_p3 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .y(y_p3), .x(x_p3)
  );

  and_1 #(.WIDTH(1), .PIPE_STAGES(0)) u_w1_p0 (
    .clk(clk), .rst(rst), .a(a8[0:0]), .b(b8[0:0]), .y(y_p0), .x(x_p0)
  );

  always @(posedge clk) begin
    hist_and.push_back(a8 & b8);
    hist_rst.push_back(rst);
  end

  // Result n edges after the operands were sampled, or 0 if any of the
  // last n edges was a reset edge.
  function automatic logic [7:0] model_y(int n, logic [7:0] mask);
    int c;
    c = hist_and.size();
    if (n == 0) return (a8 & b8) & mask;
    for (int k = 1; k <= n; k++) begin
      if (hist_rst[c-k]) return 8'h00;
    end
    return hist_and[c-n] & mask;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a8  = 8'hFF;
    b8  = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (y_p1 !== 1'b0 || x_p1 !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_w1 edge %0d: y=%b x=%b expected y=0 x=1", i, y_p1, x_p1);
      end
      n_checks++;
      if (y_p3 !== 8'h00 || x_p3 !== 8'hFF) begin
        n_fail++;
        $display("FAIL reset_w8 edge %0d: y=%h x=%h expected y=00 x=ff", i, y_p3, x_p3);
      end
    end
  endtask

  task automatic test_walk();
    logic [1:0] pat[5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
    logic       exp_y[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a8 = {7'd0, pat[i][1]};
      b8 = {7'd0, pat[i][0]};
      tick();
      n_checks++;
      if (y_p1 !== exp_y[i] || x_p1 !== ~exp_y[i]) begin
        n_fail++;
        $display("FAIL walk step %0d: y=%b x=%b expected y=%b x=%b",
                 i, y_p1, x_p1, exp_y[i], ~exp_y[i]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    rst = 1'b0;
    a8  = 8'h01;
    b8  = 8'h01;
    tick();
    n_checks++;
    if (y_p1 !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pre: y=%b expected 1", y_p1);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (y_p1 !== 1'b0 || x_p1 !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_rst: y=%b x=%b expected y=0 x=1", y_p1, x_p1);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (y_p1 !== 1'b1 || x_p1 !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_post: y=%b x=%b expected y=1 x=0", y_p1, x_p1);
    end
    // The three-stage cell must stay flushed until its pipe refills.
    n_checks++;
    if (y_p3 !== 8'h00 || x_p3 !== 8'hFF) begin
      n_fail++;
      $display("FAIL mid_flush_w8: y=%h x=%h expected y=00 x=ff", y_p3, x_p3);
    end
  endtask

  task automatic test_latency();
    logic [7:0] exp_y[3] = '{8'h00, 8'h00, 8'h30};
    rst = 1'b0;
    a8  = 8'h00;
    b8  = 8'h00;
    for (int i = 0; i < 4; i++) tick();
    a8 = 8'hF0;
    b8 = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (y_p3 !== exp_y[i] || x_p3 !== ~exp_y[i]) begin
        n_fail++;
        $display("FAIL latency edge %0d: y=%h x=%h expected y=%h x=%h",
                 i + 1, y_p3, x_p3, exp_y[i], ~exp_y[i]);
      end
    end
  endtask

  task automatic test_comb();
    a8 = 8'h01;
    b8 = 8'h01;
    for (int i = 0; i < 4; i++) begin
      rst = i[0];
      #1;
      n_checks++;
      if (y_p0 !== 1'b1 || x_p0 !== 1'b0) begin
        n_fail++;
        $display("FAIL comb rst=%b: y=%b x=%b expected y=1 x=0", rst, y_p0, x_p0);
      end
      tick();
      n_checks++;
      if (y_p0 !== 1'b1 || x_p0 !== 1'b0) begin
        n_fail++;
        $display("FAIL comb_edge rst=%b: y=%b x=%b expected y=1 x=0", rst, y_p0, x_p0);
      end
    end
    b8 = 8'h00;
    #1;
    n_checks++;
    if (y_p0 !== 1'b0 || x_p0 !== 1'b1) begin
      n_fail++;
      $display("FAIL comb_10: y=%b x=%b expected y=0 x=1", y_p0, x_p0);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [7:0] e1, e3, e0;
    int errs = 0;
    for (int i = 0; i < 1000; i++) begin
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      rst = ($urandom_range(0, 49) == 0);
      #1;
      e0 = model_y(0, 8'h01);
      n_checks++;
      if (y_p0 !== e0[0:0] || x_p0 !== ~y_p0) begin
        n_fail++;
        if (errs++ < 10) $display("FAIL rand_p0 cyc %0d: y=%b x=%b expected y=%b", i, y_p0, x_p0, e0[0]);
      end
      tick();
      e1 = model_y(1, 8'h01);
      e3 = model_y(3, 8'hFF);
      n_checks++;
      if (y_p1 !== e1[0:0] || x_p1 !== ~e1[0:0]) begin
        n_fail++;
        if (errs++ < 10) $display("FAIL rand_p1 cyc %0d: y=%b x=%b expected y=%b", i, y_p1, x_p1, e1[0]);
      end
      n_checks++;
      if (y_p3 !== e3 || x_p3 !== ~e3) begin
        n_fail++;
        if (errs++ < 10) $display("FAIL rand_p3 cyc %0d: y=%h x=%h expected y=%h x=%h", i, y_p3, x_p3, e3, ~e3);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_walk();
    test_reset_midstream();
    test_latency();
    test_comb();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
